sram_bank_array: RTL and testbench

//   Responder side of the MEMController SRAM interface: Nums_SRAM independent single-clock SRAM banks.

---
 rtl/sram_bank_array.sv | 113 +++++++++++
 tb/tb_sram_bank_array.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sram_bank_array.sv
// Bank array for the MEMController responder: Nums_SRAM independent single-clock SRAM banks,
// each with a registered read port and a hardware zero-sweep clear reported on Clear_Busy.
module sram_bank_array #(
   parameter int Addr_Width = 4,
   parameter int Ram_Depth  = 1 << Addr_Width,
   parameter int Nums_SRAM  = 3,
   parameter int Data_Width = 8
) (
   input  logic                            clk,
   input  logic                            Mem_reset,
   input  logic [Nums_SRAM-1:0]            Mem_Clear,
   input  logic [Nums_SRAM-1:0]            En_Chip_Select,
   input  logic [Nums_SRAM-1:0]            En_Write,
   input  logic [Nums_SRAM-1:0]            En_Read,
   input  logic [Nums_SRAM*Addr_Width-1:0] Addr_Read,
   input  logic [Nums_SRAM*Addr_Width-1:0] Addr_Write,
   input  logic [Nums_SRAM*Data_Width-1:0] Data_Write,
   output logic [Nums_SRAM*Data_Width-1:0] Data_Read,
   output logic [Nums_SRAM-1:0]            Read_Valid,
   output logic [Nums_SRAM-1:0]            Clear_Busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   localparam logic [Addr_Width-1:0] LAST_PTR = Addr_Width'(Ram_Depth - 1);

   for (genvar i = 0; i < Nums_SRAM; i++) begin : g_bank
      state_e                state_q, state_d;
      logic [Addr_Width-1:0] ptr_q, ptr_d;
      logic [Data_Width-1:0] mem_q [Ram_Depth];
      logic [Data_Width-1:0] rdata_q;
      logic                  rvalid_q;
      logic                  wr_en, rd_en, clr_we;
      logic [Addr_Width-1:0] addr_rd, addr_wr;
      logic [Data_Width-1:0] data_wr;

      assign addr_rd = Addr_Read[Addr_Width*i +: Addr_Width];
      assign addr_wr = Addr_Write[Addr_Width*i +: Addr_Width];
      assign data_wr = Data_Write[Data_Width*i +: Data_Width];

      always_ff @(posedge clk) begin
         if (!Mem_reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
         end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
         end
      end

      // Clear requests arriving mid-sweep are ignored; a level still high at the end re-arms.
      always_comb begin
         state_d = state_q;
         ptr_d   = ptr_q;
         case (state_q)
            ST_IDLE: begin
               if (Mem_Clear[i]) begin
                  state_d = ST_CLEAR;
                  ptr_d   = '0;
               end
            end
            ST_CLEAR: begin
               ptr_d = ptr_q + 1'b1;
               if (ptr_q == LAST_PTR) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // A clear sampled in IDLE takes priority and drops any coincident access.
      always_comb begin
         wr_en  = 1'b0;
         rd_en  = 1'b0;
         clr_we = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!Mem_Clear[i] && En_Chip_Select[i]) begin
                  wr_en = En_Write[i];
                  rd_en = En_Read[i];
               end
            end
            ST_CLEAR: clr_we = 1'b1;
            default: ;
         endcase
      end

      // Array has no reset, but no write may land on a reset edge (aborted sweep stays partial).
      always_ff @(posedge clk) begin
         if (Mem_reset) begin
            if (clr_we)     mem_q[ptr_q]   <= '0;
            else if (wr_en) mem_q[addr_wr] <= data_wr;
         end
      end

      always_ff @(posedge clk) begin
         if (!Mem_reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else begin
            rvalid_q <= rd_en;
            if (rd_en) rdata_q <= mem_q[addr_rd];
         end
      end

      assign Data_Read[Data_Width*i +: Data_Width] = rdata_q;
      assign Read_Valid[i]                         = rvalid_q;
      assign Clear_Busy[i]                         = (state_q == ST_CLEAR);
   end

endmodule

// File: tb/tb_sram_bank_array.sv
// Directed bench for sram_bank_array: reads are scored against a queue of expected
// {bank, data} entries pushed when each read is issued and drained one edge later.
module tb_sram_bank_array;

  logic        clk = 1'b0;
  logic        Mem_reset;
  logic [2:0]  Mem_Clear, En_Chip_Select, En_Write, En_Read;
  logic [11:0] Addr_Read, Addr_Write;
  logic [23:0] Data_Write;
  logic [23:0] Data_Read;
  logic [2:0]  Read_Valid, Clear_Busy;

  int checks = 0;
  int errors = 0;

  logic [9:0]  exp_q[$];
  logic [23:0] shadow_data;

  sram_bank_array dut (
    .clk(clk), .Mem_reset(Mem_reset), .Mem_Clear(Mem_Clear),
    .En_Chip_Select(En_Chip_Select), .En_Write(En_Write), .En_Read(En_Read),
    .Addr_Read(Addr_Read), .Addr_Write(Addr_Write), .Data_Write(Data_Write),
    .Data_Read(Data_Read), .Read_Valid(Read_Valid), .Clear_Busy(Clear_Busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    Mem_Clear      = '0;
    En_Chip_Select = '0;
    En_Write       = '0;
    En_Read        = '0;
  endtask

  task automatic wr(input int b, input logic [3:0] a, input logic [7:0] d);
    En_Chip_Select[b]     = 1'b1;
    En_Write[b]           = 1'b1;
    Addr_Write[4*b +: 4]  = a;
    Data_Write[8*b +: 8]  = d;
  endtask

  // Issue a read that must not produce Read_Valid.
  task automatic rd_nx(input int b, input logic [3:0] a);
    En_Chip_Select[b]    = 1'b1;
    En_Read[b]           = 1'b1;
    Addr_Read[4*b +: 4]  = a;
  endtask

  task automatic rd(input int b, input logic [3:0] a, input logic [7:0] d);
    rd_nx(b, a);
    exp_q.push_back({b[1:0], d});
  endtask

  // One clock: drain expected reads for this edge, compare valid and held data, idle inputs.
  task automatic tick(input string tag);
    logic       rst_s;
    logic [2:0] ev;
    logic [9:0] e;
    rst_s = Mem_reset;
    ev    = '0;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      shadow_data = '0;
      exp_q.delete();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ev[e[9:8]] = 1'b1;
      shadow_data[8*e[9:8] +: 8] = e[7:0];
    end
    chk({tag, "_valid"}, {21'd0, Read_Valid}, {21'd0, ev});
    chk({tag, "_data"}, Data_Read, shadow_data);
    idle_inputs();
  endtask

  initial begin
    int n;
    int guard;
    shadow_data = '0;
    Addr_Read   = '0;
    Addr_Write  = '0;
    Data_Write  = '0;
    idle_inputs();

    // Reset state
    Mem_reset = 1'b0;
    tick("rst0");
    tick("rst1");
    chk("rst_busy", {21'd0, Clear_Busy}, 24'd0);
    Mem_reset = 1'b1;

    // Basic write then read; valid is a single-cycle pulse
    wr(0, 4'd3, 8'hA5); tick("t1_wr");
    rd(0, 4'd3, 8'hA5); tick("t1_rd");
    tick("t1_after");

    // Read-first on same-address collision
    wr(0, 4'd5, 8'h01); tick("t2_wr");
    wr(0, 4'd5, 8'h07); rd(0, 4'd5, 8'h01); tick("t2_coll");
    rd(0, 4'd5, 8'h07); tick("t2_rd");

    // Reference contents in banks 0 and 2
    wr(0, 4'd9, 8'h11); wr(2, 4'd9, 8'h22); tick("ref_wr");
    wr(2, 4'd7, 8'h5A); tick("ref_wr2");

    // Clear sweep on bank 1
    for (int a = 0; a < 16; a++) begin
      wr(1, a[3:0], 8'hFF); tick("t3_fill");
    end
    Mem_Clear[1] = 1'b1; tick("t3_clr");
    n = Clear_Busy[1] ? 1 : 0;
    guard = 0;
    while (Clear_Busy[1] && guard < 40) begin
      rd_nx(1, guard[3:0]); tick("t3_sweep");
      if (Clear_Busy[1]) n++;
      guard++;
    end
    chk("t3_busy_cycles", n, 16);
    for (int a = 0; a < 16; a++) begin
      rd(1, a[3:0], 8'h00); tick("t3_zero");
    end
    rd(0, 4'd9, 8'h11); rd(2, 4'd9, 8'h22); tick("t3_others");

    // Chip select low blocks write and read
    En_Chip_Select[2] = 1'b0; En_Write[2] = 1'b1; En_Read[2] = 1'b1;
    Addr_Write[8 +: 4] = 4'd7; Data_Write[16 +: 8] = 8'h3C; Addr_Read[8 +: 4] = 4'd7;
    tick("t4_cs0");
    rd(2, 4'd7, 8'h5A); tick("t4_rd");

    // Reset during the 6th sweep cycle leaves a partial clear
    for (int a = 0; a < 16; a++) begin
      wr(0, a[3:0], 8'hFF); tick("t5_fill");
    end
    Mem_Clear[0] = 1'b1; tick("t5_clr");
    chk("t5_busy_on", {21'd0, Clear_Busy}, 24'd1);
    for (int k = 0; k < 5; k++) tick("t5_sweep");
    Mem_reset = 1'b0; tick("t5_rst");
    chk("t5_busy_off", {21'd0, Clear_Busy}, 24'd0);
    Mem_reset = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd(0, a[3:0], (a < 5) ? 8'h00 : 8'hFF); tick("t5_rd");
    end

    // All banks in parallel
    wr(0, 4'd2, 8'hC1); wr(1, 4'd4, 8'hC2); wr(2, 4'd6, 8'hC3); tick("t6_wr");
    rd(0, 4'd2, 8'hC1); rd(1, 4'd4, 8'hC2); rd(2, 4'd6, 8'hC3); tick("t6_rd");

    // Clear wins over a coincident read/write in IDLE
    Mem_Clear[2] = 1'b1; wr(2, 4'd1, 8'h77); rd_nx(2, 4'd1); tick("t7_clr");
    chk("t7_busy", {21'd0, Clear_Busy}, 24'd4);
    guard = 0;
    while (Clear_Busy[2] && guard < 40) begin
      tick("t7_sweep");
      guard++;
    end
    chk("t7_sweep_len", guard, 16);
    rd(2, 4'd1, 8'h00); rd(0, 4'd2, 8'hC1); tick("t7_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
